// File: rtl/sdr_mon_pkg.sv
// Shared types and address helpers for the SDRAM pin-side command monitor.
// Widths here are the native geometry: 13-bit row, 2-bit bank, 11-bit column.
package sdr_mon_pkg;

    localparam int ROW_W     = 13;
    localparam int BA_W      = 2;
    localparam int COL_W     = 11;
    localparam int ADDR_W    = 26;
    localparam int NUM_BANKS = 4;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_e;

    function automatic int unsigned col_width(input logic [1:0] colbits);
        return 32'd8 + {30'd0, colbits};
    endfunction

    // Linear address = {row, ba, col[w-1:0]} right-aligned, upper bits zero.
    function automatic logic [ADDR_W-1:0] addr_pack(
        input logic [ROW_W-1:0] row,
        input logic [BA_W-1:0]  ba,
        input logic [COL_W-1:0] col,
        input logic [1:0]       colbits
    );
        logic [ADDR_W-1:0] addr;
        int unsigned       w;
        w    = col_width(colbits);
        addr = ADDR_W'(col) & ((ADDR_W'(1) << w) - ADDR_W'(1));
        addr = addr | (ADDR_W'(ba) << w) | (ADDR_W'(row) << (w + BA_W));
        return addr;
    endfunction

endpackage

// File: rtl/sdr_beat_gen.sv
// Burst beat generator: sequential/wrapping column counter plus a delay line
// that shifts read beats out by the CAS latency.
module sdr_beat_gen
    import sdr_mon_pkg::*;
#(
    parameter int MAX_CAS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 start_write,
    input  logic [ROW_W-1:0]     start_row,
    input  logic [BA_W-1:0]      start_ba,
    input  logic [COL_W-1:0]     start_col,
    input  logic                 stop,
    input  logic [NUM_BANKS-1:0] close_mask,
    input  logic [1:0]           colbits,
    input  logic [2:0]           cas,
    input  logic [3:0]           burst_len,
    output logic                 beat_valid,
    output logic                 beat_write,
    output logic [ADDR_W-1:0]    beat_addr,
    output logic                 beat_clash
);
    localparam int CW = $clog2(MAX_CAS + 1);

    logic             active_reg, active_next;
    logic             write_reg, write_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [BA_W-1:0]  ba_reg, ba_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [3:0]       left_reg, left_next;

    logic             emit, emit_write;
    logic [ROW_W-1:0] emit_row;
    logic [BA_W-1:0]  emit_ba;
    logic [COL_W-1:0] emit_col;
    logic [COL_W-1:0] wrap_mask;

    // Stage 0 is the undelayed beat stream; read beats are tapped at stage cas.
    logic              pipe_valid_reg [0:MAX_CAS];
    logic              pipe_write_reg [0:MAX_CAS];
    logic [ADDR_W-1:0] pipe_addr_reg  [0:MAX_CAS];

    logic [CW-1:0] cas_idx;
    logic          wr_hit, rd_hit;

    function automatic logic [COL_W-1:0] wrap_inc(input logic [COL_W-1:0] col,
                                                  input logic [COL_W-1:0] mask);
        return (col & ~mask) | ((col + COL_W'(1)) & mask);
    endfunction

    assign wrap_mask = COL_W'(burst_len) - COL_W'(1);

    always_comb begin
        active_next = active_reg;
        write_next  = write_reg;
        row_next    = row_reg;
        ba_next     = ba_reg;
        col_next    = col_reg;
        left_next   = left_reg;
        emit        = 1'b0;
        emit_write  = write_reg;
        emit_row    = row_reg;
        emit_ba     = ba_reg;
        emit_col    = col_reg;
        if (start) begin
            emit        = 1'b1;
            emit_write  = start_write;
            emit_row    = start_row;
            emit_ba     = start_ba;
            emit_col    = start_col;
            write_next  = start_write;
            row_next    = start_row;
            ba_next     = start_ba;
            col_next    = wrap_inc(start_col, wrap_mask);
            left_next   = burst_len - 4'd1;
            active_next = (burst_len > 4'd1);
        end else if (active_reg) begin
            if (stop || close_mask[ba_reg]) begin
                active_next = 1'b0;
            end else begin
                emit        = 1'b1;
                col_next    = wrap_inc(col_reg, wrap_mask);
                left_next   = left_reg - 4'd1;
                active_next = (left_reg > 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            write_reg  <= 1'b0;
            row_reg    <= '0;
            ba_reg     <= '0;
            col_reg    <= '0;
            left_reg   <= '0;
            for (int i = 0; i <= MAX_CAS; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_write_reg[i] <= 1'b0;
                pipe_addr_reg[i]  <= '0;
            end
        end else begin
            active_reg <= active_next;
            write_reg  <= write_next;
            row_reg    <= row_next;
            ba_reg     <= ba_next;
            col_reg    <= col_next;
            left_reg   <= left_next;
            pipe_valid_reg[0] <= emit;
            pipe_write_reg[0] <= emit & emit_write;
            pipe_addr_reg[0]  <= emit ? addr_pack(emit_row, emit_ba, emit_col, colbits) : '0;
            for (int i = 1; i <= MAX_CAS; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_write_reg[i] <= pipe_write_reg[i-1];
                pipe_addr_reg[i]  <= pipe_addr_reg[i-1];
            end
        end
    end

    // Write beats win a collision with a delayed read beat.
    always_comb begin
        if (cas == 3'd0)
            cas_idx = CW'(1);
        else if (cas > 3'(MAX_CAS))
            cas_idx = CW'(MAX_CAS);
        else
            cas_idx = CW'(cas);
        wr_hit     = pipe_valid_reg[0] & pipe_write_reg[0];
        rd_hit     = pipe_valid_reg[cas_idx] & ~pipe_write_reg[cas_idx];
        beat_valid = wr_hit | rd_hit;
        beat_write = wr_hit;
        beat_clash = wr_hit & rd_hit;
        beat_addr  = wr_hit ? pipe_addr_reg[0] : (rd_hit ? pipe_addr_reg[cas_idx] : '0);
    end

endmodule

// File: rtl/sdr_cmd_addr_decoder.sv
// Passive SDRAM command-bus monitor: decodes commands, tracks open rows per bank
// and rebuilds the linear host address of each READ/WRITE and data beat.
module sdr_cmd_addr_decoder
    import sdr_mon_pkg::*;
#(
    parameter int SDR_ROW_W = ROW_W,
    parameter int SDR_BA_W  = BA_W,
    parameter int APP_AW    = ADDR_W,
    parameter int MAX_CAS   = 3
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic [1:0]           cfg_colbits,
    input  logic [2:0]           cfg_sdr_cas,
    input  logic [3:0]           cfg_burst_len,
    input  logic                 sdr_cs_n,
    input  logic                 sdr_ras_n,
    input  logic                 sdr_cas_n,
    input  logic                 sdr_we_n,
    input  logic [SDR_BA_W-1:0]  sdr_ba,
    input  logic [SDR_ROW_W-1:0] sdr_addr,
    output logic                 txn_valid,
    output logic                 txn_write,
    output logic [APP_AW-1:0]    txn_addr,
    output logic                 beat_valid,
    output logic                 beat_write,
    output logic [APP_AW-1:0]    beat_addr,
    output logic [3:0]           open_mask,
    output logic                 err_act_open,
    output logic                 err_no_row,
    output logic                 err_ref_open,
    output logic                 err_beat_clash
);
    cmd_e                 cmd;
    logic [COL_W-1:0]     col;
    logic [NUM_BANKS-1:0] bank_bit, act_hit, pre_close, close_hit, open_vec;
    logic [SDR_ROW_W-1:0] row_tab [NUM_BANKS];
    logic                 bank_open, is_rw, accept;

    always_comb begin
        cmd       = sdr_cs_n ? CMD_NOP : cmd_e'({sdr_ras_n, sdr_cas_n, sdr_we_n});
        col       = {sdr_addr[11], sdr_addr[9:0]};
        bank_bit  = NUM_BANKS'(1) << sdr_ba;
        bank_open = open_vec[sdr_ba];
        is_rw     = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        accept    = is_rw && bank_open;
        act_hit   = (cmd == CMD_ACT) ? bank_bit : '0;
        pre_close = '0;
        if (cmd == CMD_PRE)
            pre_close = sdr_addr[10] ? '1 : bank_bit;
        // Auto-precharge closes the bank but lets the accepted burst run out.
        close_hit = pre_close | ((accept && sdr_addr[10]) ? bank_bit : '0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic                 open_reg;
            logic [SDR_ROW_W-1:0] row_reg;
            always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
                if (!sdram_resetn) begin
                    open_reg <= 1'b0;
                    row_reg  <= '0;
                end else if (act_hit[gi]) begin
                    open_reg <= 1'b1;
                    row_reg  <= sdr_addr;
                end else if (close_hit[gi]) begin
                    open_reg <= 1'b0;
                end
            end
            assign open_vec[gi] = open_reg;
            assign row_tab[gi]  = row_reg;
        end
    endgenerate

    assign open_mask = open_vec;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            txn_valid    <= 1'b0;
            txn_write    <= 1'b0;
            txn_addr     <= '0;
            err_act_open <= 1'b0;
            err_no_row   <= 1'b0;
            err_ref_open <= 1'b0;
        end else begin
            txn_valid    <= accept;
            txn_write    <= accept && (cmd == CMD_WRITE);
            txn_addr     <= accept ? addr_pack(row_tab[sdr_ba], sdr_ba, col, cfg_colbits) : '0;
            err_act_open <= (cmd == CMD_ACT) && bank_open;
            err_no_row   <= is_rw && !bank_open;
            err_ref_open <= (cmd == CMD_REF) && (|open_vec);
        end
    end

    sdr_beat_gen #(
        .MAX_CAS(MAX_CAS)
    ) u_beat_gen (
        .clk        (sdram_clk),
        .rst_n      (sdram_resetn),
        .start      (accept),
        .start_write(cmd == CMD_WRITE),
        .start_row  (row_tab[sdr_ba]),
        .start_ba   (sdr_ba),
        .start_col  (col),
        .stop       (cmd == CMD_BST),
        .close_mask (pre_close),
        .colbits    (cfg_colbits),
        .cas        (cfg_sdr_cas),
        .burst_len  (cfg_burst_len),
        .beat_valid (beat_valid),
        .beat_write (beat_write),
        .beat_addr  (beat_addr),
        .beat_clash (err_beat_clash)
    );

endmodule
